counter_seq_checker: RTL and testbench
======================================

// Module: counter_seq_checker
// PURPOSE
//  Receive-side monitor for the 3-bit LED counter outputs of generated counter circuits.
//  Samples the count bus once per enabled clock and checks it advances by exactly one
//  (mod 2^WIDTH) in the selected direction. Reports lock, step errors and a stuck
//  (static) counter. Sits beside a counter DUT in simulation/FPGA builds as a
//  self-checking consumer.
// PARAMETERS
//  WIDTH        3   count bus width; wrap modulus 2^WIDTH
//  LOCK_COUNT   2   consecutive good steps needed to enter LOCKED (>=1)
//  STUCK_LIMIT  4   consecutive identical samples that assert stuck (>=2)
//  ERRCNT_W     8   error counter width (saturating)
// PORTS
//  input_clock1_1     in   1         single clock, rising edge
//  input_reset1_2     in   1         synchronous reset, active-high
//  input_enable_3     in   1         sample strobe; 0 = hold all state, no sampling
//  input_down_4       in   1         0 = expect +1 per sample, 1 = expect -1
//  input_count_5      in   WIDTH     count bus from counter (led1 = bit0)
//  output_locked_0_6  out  1         high while FSM in LOCKED
//  output_error_0_7   out  1         one-cycle pulse on step mismatch while LOCKED
//  output_stuck_0_8   out  1         static-counter flag
//  output_errcnt_0_9  out  ERRCNT_W  mismatches seen while LOCKED, saturating
// BEHAVIOUR
//  - Reset (edge with reset=1): state=EMPTY, prev=0, run=0, same=0; locked=0,
//    error=0, stuck=0, errcnt=0. Reset wins over enable in the same cycle.
//  - All outputs registered; update on the same edge that samples input_count_5.
//  - enable=0: state, prev, run, same, stuck, errcnt hold; error forced 0.
//  - exp = down ? prev-1 : prev+1, truncated to WIDTH (7+1->0, 0-1->7).
//  - FSM, per enabled sample s:
//    EMPTY   : prev<=s, ->ACQUIRE, run=0. No check.
//    ACQUIRE : s==exp -> run++; if run+1==LOCK_COUNT ->LOCKED. Else run=0.
//              No error pulse, no errcnt change.
//    LOCKED  : s==exp -> stay. Else error=1 for this cycle, errcnt++ (hold at
//              all-ones), ->ACQUIRE with run=0.
//    prev<=s on every enabled sample in every state.
//  - Hold (s==prev) is a mismatch like any other.
//  - Stuck: same++ when s==prev (saturate at STUCK_LIMIT), else same=0.
//    stuck=1 when same reaches STUCK_LIMIT-1 repeats (i.e. STUCK_LIMIT equal
//    samples). Clears on the first differing sample.
//  - input_down_4 is sampled with the count. A direction change while LOCKED
//    makes the next step a mismatch, unless the values happen to match.
//  - Reset mid-LOCKED: all state cleared; the next enabled sample is treated as
//    the first (EMPTY).
// TESTING
//  1 reset=1 two cycles -> locked=0, error=0, stuck=0, errcnt=0 at every output.
//  2 up, count 0,1,2..7,0,1 each cycle -> locked=1 from the 3rd sample (value 2),
//    stays 1 across the 7->0 wrap, errcnt=0.
//  3 count held 111 for 6 samples -> stuck=1 from the 4th sample, locked never 1,
//    errcnt=0. Then count 000 -> stuck=0.
//  4 locked up-count 2,3,5,6,7 -> error pulse exactly at sample 5, errcnt=1,
//    locked=0 at 5 and 6, locked=1 again at 7.
//  5 down=1, count 5,4,3,2,1,0,7 -> locked from 3, no error at the 0->7 wrap.
//    Toggling enable=0 for 3 cycles mid-sequence changes no output.
//  6 Cycle lock/skip 300 times -> errcnt saturates at 255.
//    reset=1 while locked -> outputs 0 next edge; relock after 3 good samples.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Receive-side monitor for a counter bus: checks each enabled sample advances by one
// (mod 2^WIDTH) in the selected direction and reports lock, step errors and a stuck counter.
module counter_seq_checker #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned LOCK_COUNT  = 2,
    parameter int unsigned STUCK_LIMIT = 4,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                input_clock1_1,
    input  logic                input_reset1_2,
    input  logic                input_enable_3,
    input  logic                input_down_4,
    input  logic [WIDTH-1:0]    input_count_5,
    output logic                output_locked_0_6,
    output logic                output_error_0_7,
    output logic                output_stuck_0_8,
    output logic [ERRCNT_W-1:0] output_errcnt_0_9
);

    localparam int unsigned RUN_W  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SAME_W = $clog2(STUCK_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ACQUIRE,
        ST_LOCKED
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [WIDTH-1:0]    exp_val;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [SAME_W-1:0]   same_q, same_d;
    logic                error_q, error_d;
    logic [ERRCNT_W-1:0] errcnt_q, errcnt_d;
    logic                match;

    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        run_d    = run_q;
        same_d   = same_q;
        error_d  = 1'b0;
        errcnt_d = errcnt_q;
        exp_val  = input_down_4 ? (prev_q - 1'b1) : (prev_q + 1'b1);
        match    = (input_count_5 == exp_val);

        if (input_enable_3) begin
            prev_d = input_count_5;
            // The first sample after reset has no predecessor, so it never counts as a repeat.
            if (state_q == ST_EMPTY || input_count_5 != prev_q) begin
                same_d = '0;
            end else if (same_q != SAME_W'(STUCK_LIMIT)) begin
                same_d = same_q + 1'b1;
            end

            unique case (state_q)
                ST_EMPTY: begin
                    state_d = ST_ACQUIRE;
                    run_d   = '0;
                end
                ST_ACQUIRE: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_q + 1'b1 == RUN_W'(LOCK_COUNT)) begin
                        state_d = ST_LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (!match) begin
                        error_d = 1'b1;
                        state_d = ST_ACQUIRE;
                        run_d   = '0;
                        if (errcnt_q != '1) begin
                            errcnt_d = errcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    run_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge input_clock1_1) begin
        if (input_reset1_2) begin
            state_q  <= ST_EMPTY;
            prev_q   <= '0;
            run_q    <= '0;
            same_q   <= '0;
            error_q  <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            run_q    <= run_d;
            same_q   <= same_d;
            error_q  <= error_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign output_locked_0_6 = (state_q == ST_LOCKED);
    assign output_error_0_7  = error_q;
    assign output_stuck_0_8  = (same_q >= SAME_W'(STUCK_LIMIT - 1));
    assign output_errcnt_0_9 = errcnt_q;

endmodule

// File: tb/tb_counter_seq_checker.sv
// Randomised and directed bench for counter_seq_checker against a behavioural model.
module tb_counter_seq_checker;

    localparam int WIDTH  = 3;
    localparam int LOCK   = 2;
    localparam int STUCK  = 4;
    localparam int ERRW   = 8;
    localparam int MOD    = 1 << WIDTH;
    localparam int ERRMAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en  = 1'b0;
    logic            dn  = 1'b0;
    logic [WIDTH-1:0] cnt = '0;
    logic            locked;
    logic            error;
    logic            stuck;
    logic [ERRW-1:0] errcnt;

    int total = 0;
    int bad   = 0;
    bit chk   = 1'b0;

    counter_seq_checker #(
        .WIDTH(WIDTH),
        .LOCK_COUNT(LOCK),
        .STUCK_LIMIT(STUCK),
        .ERRCNT_W(ERRW)
    ) dut (
        .input_clock1_1(clk),
        .input_reset1_2(rst),
        .input_enable_3(en),
        .input_down_4(dn),
        .input_count_5(cnt),
        .output_locked_0_6(locked),
        .output_error_0_7(error),
        .output_stuck_0_8(stuck),
        .output_errcnt_0_9(errcnt)
    );

    always #5 clk = ~clk;

    // Model: sample history, good-step streak and a locked flag.
    bit  m_have = 1'b0;
    int  m_prev = 0;
    int  m_streak = 0;
    bit  m_locked = 1'b0;
    bit  m_err = 1'b0;
    int  m_errcnt = 0;
    int  m_exp;
    int  hist[$];

    function automatic bit model_stuck();
        if (hist.size() < STUCK) return 1'b0;
        foreach (hist[i]) if (hist[i] != hist[0]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_have = 1'b0; m_prev = 0; m_streak = 0; m_locked = 1'b0;
            m_err = 1'b0; m_errcnt = 0; hist.delete();
        end else if (!en) begin
            m_err = 1'b0;
        end else begin
            m_exp = dn ? (m_prev + MOD - 1) % MOD : (m_prev + 1) % MOD;
            m_err = 1'b0;
            if (m_have) begin
                if (m_locked) begin
                    if (int'(cnt) != m_exp) begin
                        m_err = 1'b1;
                        m_locked = 1'b0;
                        m_streak = 0;
                        if (m_errcnt < ERRMAX) m_errcnt++;
                    end
                end else if (int'(cnt) == m_exp) begin
                    m_streak++;
                    if (m_streak >= LOCK) begin
                        m_locked = 1'b1;
                        m_streak = 0;
                    end
                end else begin
                    m_streak = 0;
                end
            end
            m_have = 1'b1;
            m_prev = int'(cnt);
            hist.push_back(int'(cnt));
            if (hist.size() > STUCK) void'(hist.pop_front());
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("locked", 32'(locked), 32'(m_locked));
            check("error",  32'(error),  32'(m_err));
            check("stuck",  32'(stuck),  32'(model_stuck()));
            check("errcnt", 32'(errcnt), 32'(m_errcnt));
        end
    end

    task automatic smp(input bit r, input bit e, input bit d, input int c);
        @(negedge clk);
        rst = r; en = e; dn = d; cnt = WIDTH'(c);
        @(posedge clk);
        #1;
    endtask

    int v;
    int cur;
    int r;

    initial begin
        // Reset
        smp(1, 1, 0, 5);
        smp(1, 0, 0, 0);
        chk = 1'b1;
        check("rst_locked", 32'(locked), 0);
        check("rst_error",  32'(error),  0);
        check("rst_stuck",  32'(stuck),  0);
        check("rst_errcnt", 32'(errcnt), 0);

        // Up count with wrap
        for (int i = 0; i < 10; i++) begin
            smp(0, 1, 0, i % MOD);
            if (i == 1) check("up_not_yet_locked", 32'(locked), 0);
            if (i == 2) check("up_locked_at_3rd", 32'(locked), 1);
        end
        check("up_wrap_locked", 32'(locked), 1);
        check("up_errcnt", 32'(errcnt), 0);

        // Stuck at 7
        smp(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            smp(0, 1, 0, 7);
            if (i == 2) check("stuck_3rd", 32'(stuck), 0);
            if (i == 3) check("stuck_4th", 32'(stuck), 1);
            check("stuck_never_locked", 32'(locked), 0);
        end
        smp(0, 1, 0, 0);
        check("stuck_clear", 32'(stuck), 0);
        check("stuck_errcnt", 32'(errcnt), 0);

        // Skip while locked
        smp(1, 0, 0, 0);
        smp(0, 1, 0, 0); smp(0, 1, 0, 1); smp(0, 1, 0, 2); smp(0, 1, 0, 3);
        smp(0, 1, 0, 5);
        check("skip_error", 32'(error), 1);
        check("skip_errcnt", 32'(errcnt), 1);
        check("skip_unlock", 32'(locked), 0);
        smp(0, 1, 0, 6);
        check("skip_error_one_cycle", 32'(error), 0);
        check("skip_still_unlocked", 32'(locked), 0);
        smp(0, 1, 0, 7);
        check("skip_relock", 32'(locked), 1);

        // Down count with wrap and enable gaps
        smp(1, 0, 0, 0);
        smp(0, 1, 1, 5); smp(0, 1, 1, 4); smp(0, 1, 1, 3);
        check("down_locked", 32'(locked), 1);
        for (int i = 0; i < 3; i++) smp(0, 0, i[0], $urandom_range(0, MOD - 1));
        check("down_hold_locked", 32'(locked), 1);
        smp(0, 1, 1, 2); smp(0, 1, 1, 1); smp(0, 1, 1, 0); smp(0, 1, 1, 7);
        check("down_wrap_locked", 32'(locked), 1);
        check("down_wrap_no_error", 32'(error), 0);
        check("down_errcnt", 32'(errcnt), 0);

        // Lock/skip cycles to saturate errcnt
        smp(1, 0, 0, 0);
        v = 0;
        smp(0, 1, 0, v);
        for (int i = 0; i < 300; i++) begin
            v += 1; smp(0, 1, 0, v % MOD);
            v += 1; smp(0, 1, 0, v % MOD);
            v += 2; smp(0, 1, 0, v % MOD);
        end
        check("sat_errcnt", 32'(errcnt), 255);
        v += 1; smp(0, 1, 0, v % MOD);
        v += 1; smp(0, 1, 0, v % MOD);
        check("sat_locked", 32'(locked), 1);
        smp(1, 1, 0, (v + 1) % MOD);
        check("midlock_rst_locked", 32'(locked), 0);
        check("midlock_rst_errcnt", 32'(errcnt), 0);
        for (int i = 0; i < 3; i++) smp(0, 1, 0, (v + 5 + i) % MOD);
        check("relock_after_rst", 32'(locked), 1);

        // Random traffic
        cur = 0;
        for (int i = 0; i < 2000; i++) begin
            r = int'($urandom_range(0, 99));
            if ($urandom_range(0, 19) == 0) dn = ~dn;
            if (r < 70)      cur = dn ? (cur + MOD - 1) % MOD : (cur + 1) % MOD;
            else if (r < 85) cur = cur;
            else             cur = int'($urandom_range(0, MOD - 1));
            smp($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85, dn, cur);
        end

        @(negedge clk);
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
